// File: rtl/onchip_mem_poller_pkg.sv
// Shared definitions for the on-chip memory poller.
// Holds the sweep FSM state type and the fixed memory map of the shared 4-word RAM.
package poller_pkg;

  localparam int unsigned MEM_WORDS    = 4;
  localparam logic [1:0]  STATUS_ADDR  = 2'd3;
  localparam int unsigned READ_LATENCY = 1;

  typedef enum logic [2:0] {
    StIdle,
    StRd0,
    StRd1,
    StRd2,
    StWr3,
    StDone
  } poller_state_t;

endpackage

// File: rtl/onchip_mem_poller_if.sv
// Avalon-MM bus between the poller (master) and the shared memory's second port (slave).
// Fixed read latency 1, no waitrequest.
//   avm_address    : word address
//   avm_chipselect : access strobe
//   avm_write      : write strobe (read when low with chipselect high)
//   avm_byteenable : byte lanes
//   avm_writedata  : write data
//   avm_readdata   : read data, valid the cycle after the read address
interface onchip_mem_poller_if;

  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write,
    output avm_byteenable,
    output avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write,
    input  avm_byteenable,
    input  avm_writedata,
    output avm_readdata
  );

endinterface

// File: rtl/onchip_mem_poller_poll_timer.sv
// Loadable down-counter that saturates at zero and flags it.
// Resets to, and reloads with, LoadVal.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   load_i     : reload with LoadVal this cycle
//   zero_o     : count is zero
module poll_timer #(
  parameter int unsigned       TIMER_W = 20,
  parameter logic [TIMER_W-1:0] LoadVal = '0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  output logic zero_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= LoadVal;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/onchip_mem_poller.sv
// Periodically sweeps the shared 4-word memory: reads control words 0-2, writes the game
// status to word 3, then publishes the three words together as one snapshot.
//   clk, reset_n    : clock, asynchronous active-low reset
//   enable          : allows timed sweeps
//   force_sweep     : request an immediate sweep (coalesced while busy)
//   status_in       : status word written to address 3
//   avm             : Avalon-MM master port
//   word0..word2    : last completed snapshot
//   snapshot_valid  : one-cycle pulse when the snapshot updates
//   busy            : sweep in progress
//   sweep_count     : completed sweeps, wrapping
module onchip_mem_poller
  import poller_pkg::*;
#(
  parameter int unsigned POLL_INTERVAL = 833333,
  parameter int unsigned TIMER_W       = 20
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       force_sweep,
  input  logic [31:0]                status_in,
  onchip_mem_poller_if.master        avm,
  output logic [31:0]                word0,
  output logic [31:0]                word1,
  output logic [31:0]                word2,
  output logic                       snapshot_valid,
  output logic                       busy,
  output logic [15:0]                sweep_count
);

  localparam logic [TIMER_W-1:0] TimerLoad = TIMER_W'(POLL_INTERVAL - 1);

  poller_state_t state_q, state_d;
  logic          pending_q, pending_d;
  logic          timer_zero;
  logic          start;

  logic [1:0]  addr_q, addr_d;
  logic        cs_q, cs_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] stage0_q, stage0_d;
  logic [31:0] stage1_q, stage1_d;
  logic [31:0] word0_q, word0_d, word1_q, word1_d, word2_q, word2_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic [15:0] count_q, count_d;

  poll_timer #(
    .TIMER_W (TIMER_W),
    .LoadVal (TimerLoad)
  ) u_timer (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .load_i (state_d == StRd0),
    .zero_o (timer_zero)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    start     = (enable && timer_zero) || force_sweep || pending_q;

    unique case (state_q)
      StIdle:  if (start) state_d = StRd0;
      StRd0:   state_d = StRd1;
      StRd1:   state_d = StRd2;
      StRd2:   state_d = StWr3;
      StWr3:   state_d = StDone;
      // A pending force chains straight into the next sweep without an idle cycle.
      StDone:  state_d = start ? StRd0 : StIdle;
      default: state_d = StIdle;
    endcase

    if (force_sweep && (state_q != StIdle)) pending_d = 1'b1;
    if (state_d == StRd0)                   pending_d = 1'b0;
  end

  // Bus and status outputs are registered and decoded from the next state.
  always_comb begin
    addr_d   = 2'd0;
    cs_d     = 1'b0;
    wr_d     = 1'b0;
    wdata_d  = 32'd0;
    stage0_d = stage0_q;
    stage1_d = stage1_q;
    word0_d  = word0_q;
    word1_d  = word1_q;
    word2_d  = word2_q;
    valid_d  = 1'b0;
    busy_d   = (state_d != StIdle);
    count_d  = count_q;

    unique case (state_d)
      StRd0: cs_d = 1'b1;
      StRd1: begin cs_d = 1'b1; addr_d = 2'd1; end
      StRd2: begin cs_d = 1'b1; addr_d = 2'd2; end
      StWr3: begin
        cs_d    = 1'b1;
        wr_d    = 1'b1;
        addr_d  = STATUS_ADDR;
        wdata_d = status_in;
      end
      StDone: begin
        valid_d = 1'b1;
        count_d = count_q + 16'd1;
      end
      default: ;
    endcase

    // Read data arrives one cycle after its address: word0 during RD1, word1 during RD2.
    if (state_q == StRd1) stage0_d = avm.avm_readdata;
    if (state_q == StRd2) stage1_d = avm.avm_readdata;
    // Word 2's data is on the bus during WR3 and goes straight into the snapshot,
    // so all three words land on the same edge.
    if (state_q == StWr3) begin
      word0_d = stage0_q;
      word1_d = stage1_q;
      word2_d = avm.avm_readdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      addr_q    <= 2'd0;
      cs_q      <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= 32'd0;
      stage0_q  <= 32'd0;
      stage1_q  <= 32'd0;
      word0_q   <= 32'd0;
      word1_q   <= 32'd0;
      word2_q   <= 32'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      cs_q      <= cs_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      stage0_q  <= stage0_d;
      stage1_q  <= stage1_d;
      word0_q   <= word0_d;
      word1_q   <= word1_d;
      word2_q   <= word2_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
    end
  end

  assign avm.avm_address    = addr_q;
  assign avm.avm_chipselect = cs_q;
  assign avm.avm_write      = wr_q;
  assign avm.avm_byteenable = cs_q ? 4'hF : 4'h0;
  assign avm.avm_writedata  = wdata_q;

  assign word0          = word0_q;
  assign word1          = word1_q;
  assign word2          = word2_q;
  assign snapshot_valid = valid_q;
  assign busy           = busy_q;
  assign sweep_count    = count_q;

endmodule
